ex_muldiv_unit: RTL and testbench

Execute-stage consumer of the ID/EX pipeline register outputs for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Owns the architectural HI/LO registers and runs a radix-2 iterative multiply/divide engine.
- Raises a stall request back toward IF/ID and ID/EX while a result is still being computed.
- All state updates on the falling edge of clock, the same edge as the pipeline registers.

---
 rtl/ex_muldiv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// Radix-2 iterative engine: shift-add for MULT/MULTU, restoring shift-subtract
// for DIV/DIVU. All state changes on the falling edge of clock, matching the
// pipeline registers. Optional macro MULDIV_FAST_MULT_EN turns MULT/MULTU into
// single-edge operations that bypass the engine; division is unaffected.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  op_valid_in,
    input  logic [5:0]            funct_in,
    input  logic [DATA_WIDTH-1:0] data_a_in,
    input  logic [DATA_WIDTH-1:0] data_b_in,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic [DATA_WIDTH-1:0] mf_result_out,
    output logic                  busy_out,
    output logic                  stall_out,
    output logic                  div_zero_out
);

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;      // mult: upper accumulator, div: partial remainder
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;      // mult: multiplier/low product, div: dividend/quotient
    logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;    // mult: multiplicand, div: divisor (magnitudes)
    logic                    is_div_q, is_div_d;
    logic                    neg_lo_q, neg_lo_d; // product or quotient must be negated
    logic                    neg_hi_q, neg_hi_d; // remainder must be negated
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic                    divz_q, divz_d;
    logic                    busy_q, busy_d;

    logic                    is_muldiv_s;
    logic                    signed_op_s;
    logic [DATA_WIDTH:0]     add_sum_s;
    logic [DATA_WIDTH:0]     shifted_s;
    logic [DATA_WIDTH:0]     diff_s;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [2*DATA_WIDTH-1:0] prod_fix_s;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*DATA_WIDTH-1:0] prod_fast_s;
`endif

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v,
                                                      input logic is_signed);
        abs_val = (is_signed && v[DATA_WIDTH-1]) ? (~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operation decode, datapath arithmetic for one engine step and final product.
    always_comb begin
        is_muldiv_s = 1'b0;
        case (funct_in)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_muldiv_s = 1'b1;
            default:                            is_muldiv_s = 1'b0;
        endcase
        // even functs (MULT, DIV) are the signed variants
        signed_op_s = ~funct_in[0];
        add_sum_s   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : {(DATA_WIDTH+1){1'b0}});
        shifted_s   = {rem_q, quo_q[DATA_WIDTH-1]};
        diff_s      = shifted_s - {1'b0, opnd_q};
        prod_s      = {rem_q, quo_q};
        prod_fix_s  = neg_lo_q ? (~prod_s + {{(2*DATA_WIDTH-1){1'b0}}, 1'b1}) : prod_s;
`ifdef MULDIV_FAST_MULT_EN
        // sign-extended operands multiplied modulo 2^(2W) give the two's-complement product
        prod_fast_s = {{DATA_WIDTH{signed_op_s & data_a_in[DATA_WIDTH-1]}}, data_a_in} *
                      {{DATA_WIDTH{signed_op_s & data_b_in[DATA_WIDTH-1]}}, data_b_in};
`endif
    end

    // Next-state logic: accept, iterate, sign-fix and HI/LO moves.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        divz_d   = divz_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid_in) begin
                    case (funct_in)
`ifdef MULDIV_FAST_MULT_EN
                        FN_MULT, FN_MULTU: begin
                            hi_d   = prod_fast_s[2*DATA_WIDTH-1:DATA_WIDTH];
                            lo_d   = prod_fast_s[DATA_WIDTH-1:0];
                            divz_d = 1'b0;
                        end
                        FN_DIV, FN_DIVU: begin
`else
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
`endif
                            is_div_d = funct_in[1];
                            opnd_d   = abs_val(data_b_in, signed_op_s);
                            quo_d    = abs_val(data_a_in, signed_op_s);
                            rem_d    = {DATA_WIDTH{1'b0}};
                            neg_lo_d = signed_op_s & (data_a_in[DATA_WIDTH-1] ^ data_b_in[DATA_WIDTH-1]);
                            neg_hi_d = signed_op_s & data_a_in[DATA_WIDTH-1];
                            divz_d   = funct_in[1] & (data_b_in == {DATA_WIDTH{1'b0}});
                            cnt_d    = CNT_WIDTH'(DATA_WIDTH);
                            state_d  = ST_RUN;
                        end
                        FN_MTHI: hi_d = data_a_in;
                        FN_MTLO: lo_d = data_a_in;
                        default: begin
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    // restoring step: keep the trial difference only if it did not go negative
                    if (!diff_s[DATA_WIDTH]) begin
                        rem_d = diff_s[DATA_WIDTH-1:0];
                        quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted_s[DATA_WIDTH-1:0];
                        quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = add_sum_s[DATA_WIDTH:1];
                    quo_d = {add_sum_s[0], quo_q[DATA_WIDTH-1:1]};
                end
                cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    // with a zero divisor the remainder path already holds |dividend|
                    lo_d = divz_q ? {DATA_WIDTH{1'b1}}
                                  : (neg_lo_q ? (~quo_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : quo_q);
                    hi_d = neg_hi_q ? (~rem_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : rem_q;
                end else begin
                    hi_d = prod_fix_s[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo_d = prod_fix_s[DATA_WIDTH-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers on the falling edge; synchronous reset wins over everything.
    always_ff @(negedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_WIDTH{1'b0}};
            rem_q    <= {DATA_WIDTH{1'b0}};
            quo_q    <= {DATA_WIDTH{1'b0}};
            opnd_q   <= {DATA_WIDTH{1'b0}};
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= {DATA_WIDTH{1'b0}};
            lo_q     <= {DATA_WIDTH{1'b0}};
            divz_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            divz_q   <= divz_d;
            busy_q   <= busy_d;
        end
    end

    // Output drive: registered architectural state plus combinational read/stall paths.
    always_comb begin
        hi_out       = hi_q;
        lo_out       = lo_q;
        busy_out     = busy_q;
        div_zero_out = divz_q;
        stall_out    = busy_q & op_valid_in & is_muldiv_s;
        case (funct_in)
            FN_MFHI: mf_result_out = hi_q;
            FN_MFLO: mf_result_out = lo_q;
            default: mf_result_out = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: a transaction-level model (plain
// 64-bit arithmetic plus an edge countdown) is compared every cycle, and a few
// directed cases are pinned with hand-computed literals.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid_in = 1'b0;
    logic [5:0]  funct_in = 6'h00;
    logic [31:0] data_a_in = 32'h0;
    logic [31:0] data_b_in = 32'h0;
    logic [31:0] hi_out, lo_out, mf_result_out;
    logic        busy_out, stall_out, div_zero_out;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0, p_hi = 32'h0, p_lo = 32'h0;
    logic        m_divz = 1'b0;
    int          m_cnt = 0;   // falling edges left until the pending result lands

    ex_muldiv_unit dut (
        .clock(clock), .reset(reset), .op_valid_in(op_valid_in), .funct_in(funct_in),
        .data_a_in(data_a_in), .data_b_in(data_b_in), .hi_out(hi_out), .lo_out(lo_out),
        .mf_result_out(mf_result_out), .busy_out(busy_out), .stall_out(stall_out),
        .div_zero_out(div_zero_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_md(input logic [5:0] f);
        return (f == 6'h10 || f == 6'h11 || f == 6'h12 || f == 6'h13 ||
                f == 6'h18 || f == 6'h19 || f == 6'h1A || f == 6'h1B);
    endfunction

    // Architectural result of a multiply/divide straight from its definition.
    task automatic ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        hi = 32'h0;
        lo = 32'h0;
        if (f == 6'h18) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (f == 6'h19) begin
            p  = {32'h0, a} * {32'h0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (f == 6'h1A) begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Advance the model across the coming falling edge using the current inputs.
    task automatic model_step();
        if (reset) begin
            m_hi = 32'h0; m_lo = 32'h0; m_divz = 1'b0; m_cnt = 0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (op_valid_in) begin
            if (funct_in >= 6'h18 && funct_in <= 6'h1B) begin
                ref_result(funct_in, data_a_in, data_b_in, p_hi, p_lo);
                m_divz = (funct_in == 6'h1A || funct_in == 6'h1B) && (data_b_in == 32'h0);
                if (FAST && (funct_in == 6'h18 || funct_in == 6'h19)) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end else begin
                    m_cnt = 33;
                end
            end else if (funct_in == 6'h11) begin
                m_hi = data_a_in;
            end else if (funct_in == 6'h13) begin
                m_lo = data_a_in;
            end
        end
    endtask

    // One clock: compare registered outputs, apply inputs, compare combinational outputs.
    task automatic cycle(input logic v, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic r);
        logic [31:0] mf_exp;
        @(posedge clock);
        chk("hi_out", hi_out, m_hi);
        chk("lo_out", lo_out, m_lo);
        chk("busy_out", busy_out, m_cnt != 0);
        chk("div_zero_out", div_zero_out, m_divz);
        op_valid_in = v; funct_in = f; data_a_in = a; data_b_in = b; reset = r;
        #1;
        mf_exp = (f == 6'h10) ? m_hi : ((f == 6'h12) ? m_lo : 32'h0);
        chk("stall_out", stall_out, (m_cnt != 0) && v && is_md(f));
        chk("mf_result_out", mf_result_out, mf_exp);
        model_step();
    endtask

    task automatic idle_n(input int n, output int busy_seen);
        busy_seen = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
            if (busy_out) busy_seen++;
        end
    endtask

    function automatic logic [31:0] pick_opnd();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3, 0) == 0) return c[$urandom_range(4, 0)];
        return $urandom();
    endfunction

    initial begin
        int          nb;
        logic [5:0]  fl [11];
        fl[0] = 6'h18; fl[1] = 6'h19; fl[2] = 6'h1A; fl[3] = 6'h1B; fl[4] = 6'h10; fl[5] = 6'h12;
        fl[6] = 6'h11; fl[7] = 6'h13; fl[8] = 6'h20; fl[9] = 6'h00; fl[10] = 6'h2A;

        repeat (2) @(negedge clock);
        cycle(1'b0, 6'h00, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        chk("reset hi", hi_out, 32'h0);
        chk("reset lo", lo_out, 32'h0);
        chk("reset busy", busy_out, 1'b0);
        chk("reset divz", div_zero_out, 1'b0);

        // reset at the tenth RUN edge abandons the multiply
        cycle(1'b1, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int k = 1; k <= 9; k++) cycle(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 6'h00, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        chk("midrst busy", busy_out, 1'b0);
        chk("midrst hi", hi_out, 32'h0);
        idle_n(40, nb);
        chk("midrst no late update lo", lo_out, 32'h0);

        // MULTU max x max, busy for exactly 33 edges
        cycle(1'b1, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle_n(40, nb);
        chk("multu busy edges", nb, FAST ? 0 : 33);
        chk("multu hi", hi_out, 32'hFFFF_FFFE);
        chk("multu lo", lo_out, 32'h0000_0001);

        // MULT -3 x 7
        cycle(1'b1, 6'h18, 32'hFFFF_FFFD, 32'h7, 1'b0);
        idle_n(40, nb);
        chk("mult busy edges", nb, FAST ? 0 : 33);
        chk("mult hi", hi_out, 32'hFFFF_FFFF);
        chk("mult lo", lo_out, 32'hFFFF_FFEB);

        // DIV -7 / 2
        cycle(1'b1, 6'h1A, 32'hFFFF_FFF9, 32'h2, 1'b0);
        idle_n(40, nb);
        chk("div busy edges", nb, 33);
        chk("div lo", lo_out, 32'hFFFF_FFFD);
        chk("div hi", hi_out, 32'hFFFF_FFFF);

        // DIV overflow case
        cycle(1'b1, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle_n(40, nb);
        chk("divovf lo", lo_out, 32'h8000_0000);
        chk("divovf hi", hi_out, 32'h0);
        chk("divovf flag", div_zero_out, 1'b0);

        // divide by zero, then flag cleared by next accept
        cycle(1'b1, 6'h1B, 32'd100, 32'h0, 1'b0);
        idle_n(40, nb);
        chk("divz lo", lo_out, 32'hFFFF_FFFF);
        chk("divz hi", hi_out, 32'd100);
        chk("divz flag", div_zero_out, 1'b1);
        cycle(1'b1, 6'h19, 32'd2, 32'd3, 1'b0);
        idle_n(40, nb);
        chk("divz cleared", div_zero_out, 1'b0);
        chk("multu 2x3 lo", lo_out, 32'd6);

        // hazard: MFLO held while busy, ADD in the middle never stalls
        cycle(1'b1, 6'h1B, 32'd1000, 32'd7, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            if (k == 10) begin
                cycle(1'b1, 6'h20, 32'h0, 32'h0, 1'b0);
                chk("add no stall", stall_out, 1'b0);
            end else begin
                cycle(1'b1, 6'h12, 32'h0, 32'h0, 1'b0);
                if (k <= 33) chk("mflo stall", stall_out, 1'b1);
                else begin
                    chk("mflo released", stall_out, 1'b0);
                    chk("mflo new lo", mf_result_out, 32'd142);
                end
            end
        end

        // MTHI/MTLO then read back
        cycle(1'b1, 6'h11, 32'hCAFE_0001, 32'h0, 1'b0);
        cycle(1'b1, 6'h13, 32'hBEEF_0002, 32'h0, 1'b0);
        cycle(1'b1, 6'h10, 32'h0, 32'h0, 1'b0);
        chk("mfhi after mthi", mf_result_out, 32'hCAFE_0001);
        chk("lo after mtlo", lo_out, 32'hBEEF_0002);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(9, 0) < 7, fl[$urandom_range(10, 0)], pick_opnd(), pick_opnd(),
                  $urandom_range(299, 0) == 0);
        end
        idle_n(40, nb);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
